// File: rtl/rapid_pkg.sv
// Shared types and constants for the RAPID-X memory stage.
package rapid_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  // RISC-V exception causes raised by the memory stage
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  // Load funct3 encodings; stores share the low two bits for size
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    logic       reg_write;
    logic [4:0] rd;
  } control_mem_s;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
  } control_wb_s;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RESP,
    MEM_DONE
  } mem_state_e;

  function automatic control_wb_s control_wb_s_default();
    control_wb_s c;
    c.reg_write = 1'b0;
    c.rd        = 5'd0;
    return c;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables/replication, load
// extraction with sign/zero extension, and the misalignment check.
module load_store_align
  import rapid_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [BE_W-1:0] o_be_c,
  output logic [XLEN-1:0] o_wdata_c,
  output logic [XLEN-1:0] o_load_data_c,
  output logic            o_misaligned_c
);

  logic [XLEN-1:0] w_shifted;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  // Access size drives byte enables, store replication and alignment
  always_comb begin
    o_be_c         = '0;
    o_wdata_c      = '0;
    o_misaligned_c = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_be_c    = BE_W'(4'b0001 << i_addr_lo);
        o_wdata_c = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be_c         = BE_W'(4'b0011 << i_addr_lo);
        o_wdata_c      = {2{i_store_data[15:0]}};
        o_misaligned_c = i_addr_lo[0];
      end
      default: begin
        o_be_c         = 4'b1111;
        o_wdata_c      = i_store_data;
        o_misaligned_c = |i_addr_lo;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    o_load_data_c = i_rdata;
    case (i_funct3)
      FUNCT3_LB:  o_load_data_c = {{24{w_byte[7]}}, w_byte};
      FUNCT3_LH:  o_load_data_c = {{16{w_half[15]}}, w_half};
      FUNCT3_LW:  o_load_data_c = i_rdata;
      FUNCT3_LBU: o_load_data_c = {24'd0, w_byte};
      FUNCT3_LHU: o_load_data_c = {16'd0, w_half};
      default:    o_load_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// RAPID-X memory stage: one data-memory transaction per instruction over a
// req/gnt/rvalid bus, producing a single-cycle writeback packet.
module memory_access_stage
  import rapid_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  control_mem_s      i_control_signal,
  input  logic [XLEN-1:0]   i_rd_output,
  input  logic [XLEN-1:0]   i_memory_data,
  output logic              o_dmem_req,
  input  logic              i_dmem_gnt,
  output logic              o_dmem_we,
  output logic [BE_W-1:0]   o_dmem_be,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_wdata,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  input  logic              i_dmem_err,
  output logic              o_valid,
  output control_wb_s       o_control_signal,
  output logic [XLEN-1:0]   o_rd_data,
  output logic              o_exception,
  output logic [3:0]        o_exc_cause
);

  localparam int unsigned     CNT_W      = 10;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  mem_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Accepted op, held until the packet is emitted
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_addr;

  // Registered outputs and their next values
  logic             r_ready;
  logic             r_dmem_req,   w_req_nxt;
  logic             r_dmem_we,    w_we_nxt;
  logic [BE_W-1:0]  r_dmem_be,    w_be_nxt;
  logic [XLEN-1:0]  r_dmem_addr,  w_addr_nxt;
  logic [XLEN-1:0]  r_dmem_wdata, w_wdata_nxt;
  logic             r_valid,      w_valid_nxt;
  control_wb_s      r_wb,         w_wb_nxt;
  logic [XLEN-1:0]  r_rd_data,    w_rd_data_nxt;
  logic             r_exception,  w_exc_nxt;
  logic [3:0]       r_exc_cause,  w_cause_nxt;

  logic             w_accept;
  logic             w_is_mem;
  logic [2:0]       w_al_funct3;
  logic [1:0]       w_al_addr_lo;
  logic [BE_W-1:0]  w_al_be;
  logic [XLEN-1:0]  w_al_wdata;
  logic [XLEN-1:0]  w_al_load;
  logic             w_al_misaligned;
  logic [3:0]       w_fault_cause;

  assign w_accept      = i_valid & r_ready;
  assign w_is_mem      = i_control_signal.mem_read | i_control_signal.mem_write;
  assign w_fault_cause = r_is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;

  // Aligner sees the incoming op in IDLE and the held op afterwards
  assign w_al_funct3  = (r_state == MEM_IDLE) ? i_control_signal.mem_funct3 : r_funct3;
  assign w_al_addr_lo = (r_state == MEM_IDLE) ? i_rd_output[1:0] : r_addr[1:0];

  load_store_align u_align (
    .i_funct3       (w_al_funct3),
    .i_addr_lo      (w_al_addr_lo),
    .i_store_data   (i_memory_data),
    .i_rdata        (i_dmem_rdata),
    .o_be_c         (w_al_be),
    .o_wdata_c      (w_al_wdata),
    .o_load_data_c  (w_al_load),
    .o_misaligned_c (w_al_misaligned)
  );

  // Next-state, bus and writeback packet decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_req_nxt     = 1'b0;
    w_we_nxt      = 1'b0;
    w_be_nxt      = '0;
    w_addr_nxt    = '0;
    w_wdata_nxt   = '0;
    w_valid_nxt   = 1'b0;
    w_wb_nxt      = control_wb_s_default();
    w_rd_data_nxt = '0;
    w_exc_nxt     = 1'b0;
    w_cause_nxt   = '0;
    case (r_state)
      MEM_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = '0;
          if (!w_is_mem) begin
            w_state_nxt        = MEM_DONE;
            w_valid_nxt        = 1'b1;
            w_wb_nxt.reg_write = i_control_signal.reg_write;
            w_wb_nxt.rd        = i_control_signal.rd;
            w_rd_data_nxt      = i_rd_output;
          end else if (w_al_misaligned) begin
            w_state_nxt   = MEM_DONE;
            w_valid_nxt   = 1'b1;
            w_wb_nxt.rd   = i_control_signal.rd;
            w_rd_data_nxt = i_rd_output;
            w_exc_nxt     = 1'b1;
            w_cause_nxt   = i_control_signal.mem_write ? CAUSE_STORE_MISALIGNED
                                                       : CAUSE_LOAD_MISALIGNED;
          end else begin
            w_state_nxt = MEM_REQ;
            w_req_nxt   = 1'b1;
            w_we_nxt    = i_control_signal.mem_write;
            w_be_nxt    = w_al_be;
            w_addr_nxt  = {i_rd_output[XLEN-1:2], 2'b00};
            w_wdata_nxt = i_control_signal.mem_write ? w_al_wdata : '0;
          end
        end
      end
      MEM_REQ: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == WAIT_LIMIT) begin
          w_state_nxt   = MEM_DONE;
          w_valid_nxt   = 1'b1;
          w_wb_nxt.rd   = r_rd;
          w_rd_data_nxt = r_addr;
          w_exc_nxt     = 1'b1;
          w_cause_nxt   = w_fault_cause;
        end else if (i_dmem_gnt) begin
          w_state_nxt = MEM_RESP;
        end else begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = r_dmem_we;
          w_be_nxt    = r_dmem_be;
          w_addr_nxt  = r_dmem_addr;
          w_wdata_nxt = r_dmem_wdata;
        end
      end
      MEM_RESP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (i_dmem_rvalid) begin
          w_state_nxt = MEM_DONE;
          w_valid_nxt = 1'b1;
          w_wb_nxt.rd = r_rd;
          if (i_dmem_err) begin
            w_rd_data_nxt = r_addr;
            w_exc_nxt     = 1'b1;
            w_cause_nxt   = w_fault_cause;
          end else if (!r_is_store) begin
            w_wb_nxt.reg_write = r_reg_write;
            w_rd_data_nxt      = w_al_load;
          end
        end else if (r_cnt == WAIT_LIMIT) begin
          w_state_nxt   = MEM_DONE;
          w_valid_nxt   = 1'b1;
          w_wb_nxt.rd   = r_rd;
          w_rd_data_nxt = r_addr;
          w_exc_nxt     = 1'b1;
          w_cause_nxt   = w_fault_cause;
        end
      end
      MEM_DONE: begin
        w_state_nxt = MEM_IDLE;
      end
      default: begin
        w_state_nxt = MEM_IDLE;
      end
    endcase
  end

  // State, held op and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_addr       <= '0;
      r_ready      <= 1'b1;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_be    <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_valid      <= 1'b0;
      r_wb         <= control_wb_s_default();
      r_rd_data    <= '0;
      r_exception  <= 1'b0;
      r_exc_cause  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ready      <= (w_state_nxt == MEM_IDLE);
      r_dmem_req   <= w_req_nxt;
      r_dmem_we    <= w_we_nxt;
      r_dmem_be    <= w_be_nxt;
      r_dmem_addr  <= w_addr_nxt;
      r_dmem_wdata <= w_wdata_nxt;
      r_valid      <= w_valid_nxt;
      r_wb         <= w_wb_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_exception  <= w_exc_nxt;
      r_exc_cause  <= w_cause_nxt;
      if (w_accept) begin
        r_is_store  <= i_control_signal.mem_write;
        r_funct3    <= i_control_signal.mem_funct3;
        r_reg_write <= i_control_signal.reg_write;
        r_rd        <= i_control_signal.rd;
        r_addr      <= i_rd_output;
      end
    end
  end

  assign o_ready          = r_ready;
  assign o_dmem_req       = r_dmem_req;
  assign o_dmem_we        = r_dmem_we;
  assign o_dmem_be        = r_dmem_be;
  assign o_dmem_addr      = r_dmem_addr;
  assign o_dmem_wdata     = r_dmem_wdata;
  assign o_valid          = r_valid;
  assign o_control_signal = r_wb;
  assign o_rd_data        = r_rd_data;
  assign o_exception      = r_exception;
  assign o_exc_cause      = r_exc_cause;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: directed ops push expected
// writeback packets; a negedge monitor pops and compares on o_valid.
module tb_memory_access_stage;
  import rapid_pkg::*;

  localparam int unsigned TB_MAX_WAIT = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  control_mem_s i_control_signal = '0;
  logic [31:0]  i_rd_output = '0;
  logic [31:0]  i_memory_data = '0;
  logic         o_dmem_req;
  logic         i_dmem_gnt = 1'b0;
  logic         o_dmem_we;
  logic [3:0]   o_dmem_be;
  logic [31:0]  o_dmem_addr;
  logic [31:0]  o_dmem_wdata;
  logic         i_dmem_rvalid = 1'b0;
  logic [31:0]  i_dmem_rdata = '0;
  logic         i_dmem_err = 1'b0;
  logic         o_valid;
  control_wb_s  o_control_signal;
  logic [31:0]  o_rd_data;
  logic         o_exception;
  logic [3:0]   o_exc_cause;

  memory_access_stage #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_control_signal (i_control_signal),
    .i_rd_output      (i_rd_output),
    .i_memory_data    (i_memory_data),
    .o_dmem_req       (o_dmem_req),
    .i_dmem_gnt       (i_dmem_gnt),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_be        (o_dmem_be),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_wdata     (o_dmem_wdata),
    .i_dmem_rvalid    (i_dmem_rvalid),
    .i_dmem_rdata     (i_dmem_rdata),
    .i_dmem_err       (i_dmem_err),
    .o_valid          (o_valid),
    .o_control_signal (o_control_signal),
    .o_rd_data        (o_rd_data),
    .o_exception      (o_exception),
    .o_exc_cause      (o_exc_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        rw;
    logic [4:0]  rd;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_pkt(input logic [31:0] d, input logic cd, input logic rw,
                            input logic [4:0] rd, input logic exc, input logic [3:0] cause);
    exp_t e;
    e.data = d; e.chk_data = cd; e.rw = rw; e.rd = rd; e.exc = exc; e.cause = cause;
    exp_q.push_back(e);
  endtask

  function automatic control_mem_s mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                      input logic rw, input logic [4:0] rd);
    control_mem_s c;
    c.mem_read = rd_en; c.mem_write = wr_en; c.mem_funct3 = f3; c.reg_write = rw; c.rd = rd;
    return c;
  endfunction

  // Writeback monitor
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_data) chk("wb_data", o_rd_data, e.data);
        chk("wb_reg_write", 32'(o_control_signal.reg_write), 32'(e.rw));
        chk("wb_rd", 32'(o_control_signal.rd), 32'(e.rd));
        chk("wb_exception", 32'(o_exception), 32'(e.exc));
        chk("wb_cause", 32'(o_exc_cause), 32'(e.cause));
      end
    end
  end

  // Issue one op once the stage is ready; returns #1 after the accepting edge
  task automatic send(input control_mem_s c, input logic [31:0] a, input logic [31:0] d);
    int guard = 0;
    @(posedge i_clk); #1;
    while (o_ready !== 1'b1 && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (guard == 20) chk("ready_wait", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_control_signal = c; i_rd_output = a; i_memory_data = d;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_control_signal = '0; i_rd_output = '0; i_memory_data = '0;
  endtask

  // Bus responder for one granted access, checking the request and latency
  task automatic do_bus(input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input int gnt_wait, input logic stale,
                        input int rv_wait, input logic [31:0] rdata, input logic err);
    @(negedge i_clk);
    chk("req_asserted", 32'(o_dmem_req), 32'd1);
    chk("req_we", 32'(o_dmem_we), 32'(exp_we));
    chk("req_be", 32'(o_dmem_be), 32'(exp_be));
    chk("req_addr", o_dmem_addr, exp_addr);
    chk("req_wdata", o_dmem_wdata, exp_wdata);
    for (int k = 0; k < gnt_wait; k++) begin
      @(negedge i_clk);
      chk("req_hold", 32'(o_dmem_req), 32'd1);
      chk("req_addr_hold", o_dmem_addr, exp_addr);
    end
    i_dmem_gnt = 1'b1;
    if (stale) begin
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111;
    end
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    @(negedge i_clk);
    chk("req_dropped", 32'(o_dmem_req), 32'd0);
    chk("resp_no_valid", 32'(o_valid), 32'd0);
    for (int k = 0; k < rv_wait; k++) @(negedge i_clk);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata; i_dmem_err = err;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0; i_dmem_rdata = '0; i_dmem_err = 1'b0;
    @(negedge i_clk);
    chk("valid_after_rvalid", 32'(o_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_be", 32'(o_dmem_be), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_exc", 32'(o_exception), 32'd0);
    #1 i_rst = 1'b0;

    // ALU passthrough: valid the cycle after accept
    expect_pkt(32'h1234_5678, 1'b1, 1'b1, 5'd5, 1'b0, 4'd0);
    send(mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd5), 32'h1234_5678, 32'h0);
    @(negedge i_clk);
    chk("pt_valid_t1", 32'(o_valid), 32'd1);
    chk("pt_no_req", 32'(o_dmem_req), 32'd0);

    // Loads from 0x80AABBCC
    expect_pkt(32'hFFFF_FF80, 1'b1, 1'b1, 5'd7, 1'b0, 4'd0);
    send(mk(1'b1, 1'b0, FUNCT3_LB, 1'b1, 5'd7), 32'h0000_1003, 32'h0);
    do_bus(1'b0, 4'b1000, 32'h0000_1000, 32'h0, 0, 1'b0, 0, 32'h80AA_BBCC, 1'b0);

    expect_pkt(32'h0000_0080, 1'b1, 1'b1, 5'd8, 1'b0, 4'd0);
    send(mk(1'b1, 1'b0, FUNCT3_LBU, 1'b1, 5'd8), 32'h0000_1003, 32'h0);
    do_bus(1'b0, 4'b1000, 32'h0000_1000, 32'h0, 0, 1'b1, 0, 32'h80AA_BBCC, 1'b0);

    expect_pkt(32'hFFFF_80AA, 1'b1, 1'b1, 5'd9, 1'b0, 4'd0);
    send(mk(1'b1, 1'b0, FUNCT3_LH, 1'b1, 5'd9), 32'h0000_1002, 32'h0);
    do_bus(1'b0, 4'b1100, 32'h0000_1000, 32'h0, 0, 1'b0, 1, 32'h80AA_BBCC, 1'b0);

    expect_pkt(32'h0000_BBCC, 1'b1, 1'b1, 5'd10, 1'b0, 4'd0);
    send(mk(1'b1, 1'b0, FUNCT3_LHU, 1'b1, 5'd10), 32'h0000_1000, 32'h0);
    do_bus(1'b0, 4'b0011, 32'h0000_1000, 32'h0, 2, 1'b0, 0, 32'h80AA_BBCC, 1'b0);

    expect_pkt(32'h80AA_BBCC, 1'b1, 1'b0, 5'd11, 1'b0, 4'd0);
    send(mk(1'b1, 1'b0, FUNCT3_LW, 1'b0, 5'd11), 32'h0000_1000, 32'h0);
    do_bus(1'b0, 4'b1111, 32'h0000_1000, 32'h0, 1, 1'b0, 2, 32'h80AA_BBCC, 1'b0);

    // Stores always complete with reg_write low
    expect_pkt(32'h0, 1'b0, 1'b0, 5'd3, 1'b0, 4'd0);
    send(mk(1'b0, 1'b1, 3'b001, 1'b1, 5'd3), 32'h0000_2002, 32'hDEAD_BEEF);
    do_bus(1'b1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 0, 1'b0, 0, 32'h0, 1'b0);

    expect_pkt(32'h0, 1'b0, 1'b0, 5'd4, 1'b0, 4'd0);
    send(mk(1'b0, 1'b1, 3'b000, 1'b1, 5'd4), 32'h0000_2001, 32'h1234_5678);
    do_bus(1'b1, 4'b0010, 32'h0000_2000, 32'h7878_7878, 1, 1'b0, 0, 32'h0, 1'b0);

    expect_pkt(32'h0, 1'b0, 1'b0, 5'd6, 1'b0, 4'd0);
    send(mk(1'b0, 1'b1, 3'b010, 1'b1, 5'd6), 32'h0000_2004, 32'hCAFE_F00D);
    do_bus(1'b1, 4'b1111, 32'h0000_2004, 32'hCAFE_F00D, 0, 1'b0, 0, 32'h0, 1'b0);

    // Misaligned accesses: no bus activity, exception at T+1
    expect_pkt(32'h0000_3001, 1'b1, 1'b0, 5'd12, 1'b1, 4'd4);
    send(mk(1'b1, 1'b0, FUNCT3_LW, 1'b1, 5'd12), 32'h0000_3001, 32'h0);
    @(negedge i_clk);
    chk("mis_lw_valid", 32'(o_valid), 32'd1);
    chk("mis_lw_no_req", 32'(o_dmem_req), 32'd0);

    expect_pkt(32'h0000_3003, 1'b1, 1'b0, 5'd13, 1'b1, 4'd6);
    send(mk(1'b0, 1'b1, 3'b001, 1'b1, 5'd13), 32'h0000_3003, 32'hAAAA_5555);
    @(negedge i_clk);
    chk("mis_sh_valid", 32'(o_valid), 32'd1);
    chk("mis_sh_no_req", 32'(o_dmem_req), 32'd0);

    expect_pkt(32'h0000_3001, 1'b1, 1'b0, 5'd14, 1'b1, 4'd4);
    send(mk(1'b1, 1'b0, FUNCT3_LHU, 1'b1, 5'd14), 32'h0000_3001, 32'h0);
    @(negedge i_clk);
    chk("mis_lhu_valid", 32'(o_valid), 32'd1);

    // Timeout: store never granted
    expect_pkt(32'h0000_4000, 1'b1, 1'b0, 5'd15, 1'b1, 4'd7);
    send(mk(1'b0, 1'b1, 3'b010, 1'b1, 5'd15), 32'h0000_4000, 32'h5A5A_5A5A);
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin
        seen = k;
        break;
      end
    end
    chk("timeout_seen", 32'(seen != 0), 32'd1);
    chk("timeout_window", 32'(seen >= int'(TB_MAX_WAIT) && seen <= int'(TB_MAX_WAIT) + 3), 32'd1);
    chk("timeout_req_low", 32'(o_dmem_req), 32'd0);
    @(negedge i_clk);
    chk("timeout_req_after", 32'(o_dmem_req), 32'd0);

    // Bus error on a load
    expect_pkt(32'h0000_5000, 1'b1, 1'b0, 5'd16, 1'b1, 4'd5);
    send(mk(1'b1, 1'b0, FUNCT3_LW, 1'b1, 5'd16), 32'h0000_5000, 32'h0);
    do_bus(1'b0, 4'b1111, 32'h0000_5000, 32'h0, 0, 1'b0, 0, 32'h0BAD_0BAD, 1'b1);

    // Reset during RESP discards the op; late rvalid ignored
    send(mk(1'b1, 1'b0, FUNCT3_LW, 1'b1, 5'd17), 32'h0000_6000, 32'h0);
    @(negedge i_clk);
    i_dmem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_req", 32'(o_dmem_req), 32'd0);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h7777_7777;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    @(negedge i_clk);
    chk("late_rvalid_ignored", 32'(o_valid), 32'd0);
    chk("late_rvalid_ready", 32'(o_ready), 32'd1);

    expect_pkt(32'hA5A5_0001, 1'b1, 1'b1, 5'd18, 1'b0, 4'd0);
    send(mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd18), 32'hA5A5_0001, 32'h0);
    @(negedge i_clk);
    chk("pt2_valid_t1", 32'(o_valid), 32'd1);

    repeat (3) @(negedge i_clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the RAPID-X core, directly downstream of `execute_logic`. It accepts the execute result from `execute_logic`: ALU/address value, store data and `control_mem_s`. It performs at most one data-memory transaction per instruction over a req/gnt/rvalid bus and formats load data with byte/half/word alignment and sign extension. It emits a one-cycle-valid writeback packet, and flags misaligned accesses, bus errors and bus timeouts as exceptions.

## Interface
Parameters:
- `MAX_WAIT`, 255: cycles allowed in REQ+RESP before a timeout access fault; range 2..1023.

Ports:
- `i_clk`  in  1  core clock
- `i_rst`  in  1  reset; synchronous, active-high
- `i_valid`  in  1  execute result valid
- `o_ready`  out  1  stage can accept (high only in IDLE)
- `i_control_signal`  in  `control_mem_s`  fields: `mem_read`, `mem_write`, `mem_funct3[2:0]`, `reg_write`, `rd[4:0]`
- `i_rd_output`  in  XLEN  ALU result; effective address for loads/stores
- `i_memory_data`  in  XLEN  store data (rs2)
- `o_dmem_req`  out  1  bus request
- `i_dmem_gnt`  in  1  request accepted
- `o_dmem_we`  out  1  write
- `o_dmem_be`  out  4  byte enables
- `o_dmem_addr`  out  XLEN  word-aligned address (`addr[1:0]`=0)
- `o_dmem_wdata`  out  XLEN  lane-replicated store data
- `i_dmem_rvalid`  in  1  response; acknowledges both reads and writes
- `i_dmem_rdata`  in  XLEN  read data
- `i_dmem_err`  in  1  error, qualified by rvalid
- `o_valid`  out  1  writeback packet valid; single-cycle pulse
- `o_control_signal`  out  `control_wb_s`  `reg_write`, `rd`
- `o_rd_data`  out  XLEN  value for rd
- `o_exception`  out  1  exception on this packet
- `o_exc_cause`  out  4  RISC-V cause: 4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Accept = `i_valid & o_ready`. The accepted op is registered and held until DONE.
- IDLE transitions on accept:
  - Neither `mem_read` nor `mem_write`: go to DONE with `o_rd_data` = `i_rd_output`.
  - Misaligned access: go to DONE with an exception and no bus activity. Halfword (`funct3[1:0]`=01) is misaligned when `addr[0]`=1; word (10) when `addr[1:0]`≠0.
  - Otherwise: go to REQ.
- REQ:
  - `o_dmem_req`=1 and the address/we/be/wdata outputs are stable until `i_dmem_gnt`.
  - `i_dmem_gnt` moves the FSM to RESP. `req` drops the cycle after gnt.
- RESP: `i_dmem_rvalid` moves the FSM to DONE and latches rdata/err.
- DONE: `o_valid`=1 for exactly one cycle, then IDLE.
- Store formatting:
  - SB: be=`0001<<addr[1:0]`, wdata = byte replicated ×4.
  - SH: be=`0011<<addr[1:0]`, wdata = half replicated ×2.
  - SW: be=`1111`.
- Load extraction selects the lane by `addr[1:0]`: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Exceptions:
  - On any exception, `o_control_signal.reg_write` is forced 0 and `o_rd_data` = the faulting address.
  - `i_dmem_err`, or the timeout counter reaching `MAX_WAIT` in REQ/RESP, gives cause 5 for a load and 7 for a store. Timeout drops `req` and enters DONE.
- Stores complete with `reg_write`=0, regardless of input.
- `rvalid` in IDLE/DONE/REQ is ignored (stale response after reset).

## Timing
- Reset values: all outputs 0 except `o_ready`=1; FSM=IDLE; wait counter=0.
- Non-memory op: accept at T, `o_valid` at T+1.
- Misaligned op: `o_valid` at T+1 with `o_exception`=1.
- Load/store with gnt at T+1 and rvalid at T+2: `o_valid` at T+3. Each extra gnt or rvalid wait cycle adds one cycle.
- Wait counter clears on accept and increments each cycle in REQ/RESP. Reaching `MAX_WAIT` forces DONE on the next edge.
- gnt and rvalid asserted in the same cycle: the rvalid is ignored; the response must follow gnt by ≥1 cycle.
- `i_rst` mid-transaction: next edge returns to IDLE with reset outputs; the pending op is discarded and not reported.
- Throughput: at most one op per 2 cycles.

## Structure
- `rapid_pkg` holds:
  - `control_mem_s` and `control_wb_s`, with `control_wb_s_default()`;
  - the `mem_state_e` enum;
  - `CAUSE_*` constants;
  - `FUNCT3_LB`..`FUNCT3_LHU`.
- One combinational sub-module, `load_store_align`: takes funct3, `addr[1:0]`, store data and rdata; produces be, wdata, extracted load value and a misaligned flag.

## Test plan
- ALU passthrough: `rd_output`=0x1234_5678, `rd`=5, `reg_write`=1 → `o_valid` at T+1, `o_rd_data`=0x1234_5678, `rd`=5.
- LB at 0x1003, rdata=0x80AA_BBCC, gnt T+1, rvalid T+2 → `o_dmem_addr`=0x1000, `o_valid` at T+3, data 0xFFFF_FF80. LBU from the same access → 0x0000_0080.
- SH at 0x2002, data 0xDEAD_BEEF → be=1100, wdata=0xBEEF_BEEF, `we`=1; `o_valid` with `reg_write`=0.
- LW at 0x3001 → no `o_dmem_req`, `o_valid` at T+1, `o_exception`=1, cause 4, `o_rd_data`=0x3001.
- Timeout: SW at 0x4000, gnt never asserted, `MAX_WAIT`=8 → `o_exception`=1, cause 7, `req` low afterwards. Then `i_dmem_err` on a load rvalid → cause 5.
- `i_rst` pulsed during RESP → IDLE, `o_ready`=1, no `o_valid`. A late rvalid is ignored, and the next passthrough op completes normally.
